cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common Data Bus arbiter and broadcast register for the LEN5 execution pipeline. Collects result requests from every execution unit (load buffer, store buffer, branch unit, ALU, multiplier, divider, FPU) and grants at most one per cycle. The granted result is registered and broadcast on the CDB to the ROB and to every reservation station. It is the arbiter end of the per-EU `cdb_valid`/`cdb_ready`/`cdb_data` handshake.

## Interface
- `EU_N`, default `len5_config_pkg::MAX_EU_N`: number of requesting execution units; any value ≥2, not necessarily a power of two.
- `clk_i` input 1: clock; all state on rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `flush_i` input 1: pipeline flush (misprediction or exception); synchronous.
- `eu_valid_i` input `EU_N`: per-EU result valid.
- `eu_ready_o` output `EU_N`: per-EU grant; at most one bit set.
- `eu_data_i` input `EU_N` × `expipe_pkg::cdb_data_t`: per-EU result payload.
- `rob_ready_i` input 1: ROB accepts the broadcast this cycle.
- `cdb_valid_o` output 1: broadcast valid.
- `cdb_data_o` output `expipe_pkg::cdb_data_t`: broadcast payload.

## Operation
- Output register: `out_valid_q` and `out_data_q` drive `cdb_valid_o` and `cdb_data_o` directly.
- `load_en = !flush_i && (!out_valid_q || rob_ready_i)`.
- Grant is combinational.
  - Select one index `g` among the set bits of `eu_valid_i` using the priority rule (see Configuration).
  - `eu_ready_o = onehot(g)` when `load_en` and any valid is set; otherwise all zero.
  - `eu_ready_o` never depends on `cdb_valid_o` of the same cycle except through `load_en`.
- Handshake: a transfer occurs when `eu_valid_i[g] && eu_ready_o[g]`.
  - On a transfer: `out_data_q <= eu_data_i[g]`, `out_valid_q <= 1`.
  - Each EU holds `valid` and `data` stable until it is granted. The arbiter may move the grant to another EU while one is waiting.
- No transfer and `rob_ready_i && out_valid_q`: `out_valid_q <= 0`.
- Round-robin pointer `ptr_q`, width `$clog2(EU_N)`.
  - On a transfer: `ptr_q <= (g == EU_N-1) ? 0 : g+1`. Wrap is explicit; no reliance on power-of-two overflow.
- Flush:
  - `out_valid_q <= 0` at the next edge, regardless of `rob_ready_i`.
  - `eu_ready_o` is all zero during the flush cycle, so no transfer occurs.
  - `out_data_q` and `ptr_q` are retained.
- No valid inputs: no grant; the pointer is unchanged.
- Reset values: `cdb_valid_o = 0`, `cdb_data_o = '0`, `eu_ready_o = '0`, `ptr_q = 0`.
- Reset mid-operation discards any pending broadcast immediately (asynchronous).

## Timing
- Latency: a grant in cycle N is broadcast on `cdb_valid_o`/`cdb_data_o` in cycle N+1.
- Throughput: one result per cycle while `rob_ready_i` is held at 1.
- Backpressure: while `cdb_valid_o = 1` and `rob_ready_i = 0`, `eu_ready_o = '0`. `cdb_data_o` is held stable until `rob_ready_i` is 1.
- Simultaneous `rob_ready_i` and a new grant: the old entry is consumed and the new one is loaded at the same edge. No bubble.
- Simultaneous `flush_i` and a pending EU valid: no grant; `cdb_valid_o = 0` next cycle.
- Combinational paths: `eu_valid_i`, `rob_ready_i`, `flush_i` → `eu_ready_o` only. Outputs to the CDB are registered.

## Configuration
- Macro `LEN5_CDB_RR_ARBITER_EN`.
  - Defined: round-robin arbitration. Priority order is `ptr_q`, `ptr_q+1`, …, `EU_N-1`, `0`, …, `ptr_q-1`.
  - Undefined: fixed priority, lowest index wins. `ptr_q` is not implemented and reads as constant 0.
- Handshake, latency and flush behaviour are identical in both builds.

## Test plan
- Reset and single request:
  - Stimulus: release reset; `eu_valid_i = 'b0000_0100`, `rob_ready_i = 1`.
  - Response: `eu_ready_o = 'b0000_0100` in cycle 0; `cdb_valid_o = 1` with EU2 payload in cycle 1. With round-robin, `ptr_q = 3`.
- All EUs requesting continuously, `EU_N = 8`, `rob_ready_i = 1`:
  - Round-robin build: grants 0,1,…,7,0 on consecutive cycles, showing the wrap.
  - Fixed-priority build: EU0 is granted every cycle.
- Backpressure:
  - Stimulus: broadcast pending, `rob_ready_i = 0` for 3 cycles, EU5 valid.
  - Response: `cdb_data_o` is stable and `eu_ready_o = 0` for 3 cycles. On the cycle `rob_ready_i = 1`, EU5 is granted; its data is broadcast the next cycle with no bubble.
- Flush with a pending broadcast:
  - Stimulus: `cdb_valid_o = 1`, `flush_i = 1`, EU1 valid.
  - Response: `eu_ready_o = 0`; `cdb_valid_o = 0` next cycle; EU1 is granted the cycle after the flush deasserts.
- Asynchronous reset mid-stream:
  - Stimulus: assert `rst_ni = 0` between clock edges while `cdb_valid_o = 1`.
  - Response: `cdb_valid_o` drops immediately; `ptr_q = 0` after release.
- Non-power-of-two `EU_N = 7`, all EUs valid (round-robin build):
  - Response: grant sequence 5,6,0,1 starting from `ptr_q = 5`. No grant to an index ≥7 ever occurs.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter and broadcast register.
// Collects result requests from the execution units, grants at most one per
// cycle and registers the winner for broadcast to the ROB and the
// reservation stations.
//
// Build option: define LEN5_CDB_RR_ARBITER_EN for round-robin arbitration.
// Without it the lowest requesting index wins and ptr_q is tied to zero.
//
// DATA_W sets the width of the broadcast payload (the packed cdb_data_t).
module cdb_arbiter #(
  parameter int EU_N   = 8,
  parameter int DATA_W = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [EU_N-1:0]              eu_valid_i,
  output logic [EU_N-1:0]              eu_ready_o,
  input  logic [EU_N-1:0][DATA_W-1:0]  eu_data_i,
  input  logic                         rob_ready_i,
  output logic                         cdb_valid_o,
  output logic [DATA_W-1:0]            cdb_data_o
);

  localparam int PTR_W = $clog2(EU_N);

  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  grant_idx;
  logic              any_valid;
  logic              load_en;
  logic              transfer;

  // The output register can take a new result when it is empty or being
  // drained this cycle; a flush blocks any new load.
  assign load_en  = !flush_i && (!out_valid_q || rob_ready_i);
  assign transfer = load_en && any_valid;

  // Scan requesters starting at ptr_q, wrapping explicitly at EU_N so that a
  // non-power-of-two EU count never selects a nonexistent index.
  always_comb begin : grant_sel
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < EU_N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= EU_N) idx = idx - EU_N;
      if (!any_valid && eu_valid_i[PTR_W'(idx)]) begin
        any_valid = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  // One-hot grant back to the winning execution unit.
  always_comb begin : ready_gen
    eu_ready_o = '0;
    if (transfer) eu_ready_o[grant_idx] = 1'b1;
  end

  // Output register next state: load on a transfer, otherwise drain on
  // ROB accept or drop on flush. Payload is retained when not loading.
  always_comb begin : out_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = eu_data_i[grant_idx];
    end else if (flush_i || rob_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Broadcast register; reset discards any pending result immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin : out_reg
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef LEN5_CDB_RR_ARBITER_EN
  logic [PTR_W-1:0] ptr_d;

  // Advance the pointer past the last winner so it gets lowest priority next.
  always_comb begin : ptr_next
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (grant_idx == PTR_W'(EU_N - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin : ptr_reg
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  assign ptr_q = '0;
`endif

  assign cdb_valid_o = out_valid_q;
  assign cdb_data_o  = out_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed steps followed by randomized traffic,
// checked against a behavioural model. Two instances: EU_N=8 and EU_N=7.
module tb_cdb_arbiter;

`ifdef LEN5_CDB_RR_ARBITER_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             fl;
  logic [7:0]       v8, er8_dut;
  logic [7:0][31:0] d8;
  logic             rr8, cv8;
  logic [31:0]      cd8;
  logic [6:0]       v7, er7_dut;
  logic [6:0][31:0] d7;
  logic             rr7, cv7;
  logic [31:0]      cd7;

  int n_vec = 0;
  int n_err = 0;

  // model state: index 0 -> EU_N=8 instance, 1 -> EU_N=7 instance
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  int          m_ptr   [2];
  int          lg8, lg7;

  always #5 clk = ~clk;

  cdb_arbiter #(.EU_N(8), .DATA_W(32)) dut8 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(fl),
    .eu_valid_i(v8), .eu_ready_o(er8_dut), .eu_data_i(d8),
    .rob_ready_i(rr8), .cdb_valid_o(cv8), .cdb_data_o(cd8)
  );

  cdb_arbiter #(.EU_N(7), .DATA_W(32)) dut7 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(fl),
    .eu_valid_i(v7), .eu_ready_o(er7_dut), .eu_data_i(d7),
    .rob_ready_i(rr7), .cdb_valid_o(cv7), .cdb_data_o(cd7)
  );

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // First requester found scanning ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int pick(input logic [7:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (ptr + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_ptr[i]   = 0;
    end
  endtask

  // Check one cycle of both instances against the model, then advance.
  task automatic cycle();
    int g8, g7;
    bit le8, le7, t8, t7;
    logic [7:0] e8;
    logic [6:0] e7;
    logic [7:0][31:0] dd7;
    #1;
    g8  = pick(v8, m_ptr[0], 8);
    g7  = pick({1'b0, v7}, m_ptr[1], 7);
    le8 = !fl && (!m_valid[0] || rr8);
    le7 = !fl && (!m_valid[1] || rr7);
    t8  = le8 && (g8 >= 0);
    t7  = le7 && (g7 >= 0);
    e8  = t8 ? (8'd1 << g8) : 8'd0;
    e7  = t7 ? (7'd1 << g7) : 7'd0;
    chk("ready8", 64'(er8_dut), 64'(e8));
    chk("valid8", 64'(cv8), 64'(m_valid[0]));
    chk("data8",  64'(cd8), 64'(m_data[0]));
    chk("ptr8",   64'(dut8.ptr_q), 64'(m_ptr[0]));
    chk("ready7", 64'(er7_dut), 64'(e7));
    chk("valid7", 64'(cv7), 64'(m_valid[1]));
    chk("data7",  64'(cd7), 64'(m_data[1]));
    chk("ptr7",   64'(dut7.ptr_q), 64'(m_ptr[1]));
    lg8 = t8 ? g8 : -1;
    lg7 = t7 ? g7 : -1;
    dd7 = {32'h0, d7};
    @(posedge clk);
    if (fl) m_valid[0] = 1'b0;
    else if (t8) begin
      m_valid[0] = 1'b1;
      m_data[0]  = d8[g8];
      m_ptr[0]   = RR ? (g8 + 1) % 8 : 0;
    end else if (rr8) m_valid[0] = 1'b0;
    if (fl) m_valid[1] = 1'b0;
    else if (t7) begin
      m_valid[1] = 1'b1;
      m_data[1]  = dd7[g7];
      m_ptr[1]   = RR ? (g7 + 1) % 7 : 0;
    end else if (rr7) m_valid[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    v8 = '0; v7 = '0; fl = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_valid8", 64'(cv8), 64'd0);
    chk("rst_data8",  64'(cd8), 64'd0);
    chk("rst_ready8", 64'(er8_dut), 64'd0);
    chk("rst_ptr8",   64'(dut8.ptr_q), 64'd0);
    chk("rst_valid7", 64'(cv7), 64'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] held;
    rst_ni = 1'b0; fl = 1'b0; rr8 = 1'b1; rr7 = 1'b1;
    v8 = '0; v7 = '0; lg8 = -1; lg7 = -1;
    for (int i = 0; i < 8; i++) d8[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 7; i++) d7[i] = 32'hB000_0000 + 32'(i);
    model_reset();
    @(negedge clk);
    do_reset();

    // single request from EU2
    v8 = 8'b0000_0100;
    #1 chk("t1_ready", 64'(er8_dut), 64'h04);
    cycle();
    v8 = '0;
    #1;
    chk("t1_valid", 64'(cv8), 64'd1);
    chk("t1_data",  64'(cd8), 64'(d8[2]));
    chk("t1_ptr",   64'(dut8.ptr_q), RR ? 64'd3 : 64'd0);
    cycle();

    // all EUs requesting continuously from a fresh reset
    do_reset();
    v8 = 8'hFF; rr8 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1 chk("rr_seq", 64'(er8_dut), RR ? 64'(8'd1 << (k % 8)) : 64'd1);
      cycle();
    end

    // backpressure: pending broadcast held for 3 cycles, EU5 waiting
    v8 = 8'b0010_0000; rr8 = 1'b0;
    #1 held = cd8;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 64'(er8_dut), 64'd0);
      chk("bp_data",  64'(cd8), 64'(held));
      chk("bp_valid", 64'(cv8), 64'd1);
      cycle();
    end
    rr8 = 1'b1;
    #1 chk("bp_grant", 64'(er8_dut), 64'h20);
    cycle();
    v8 = '0;
    #1;
    chk("bp_out_valid", 64'(cv8), 64'd1);
    chk("bp_out_data",  64'(cd8), 64'(d8[5]));

    // flush with pending broadcast, EU1 valid
    fl = 1'b1; v8 = 8'b0000_0010;
    #1 chk("fl_ready", 64'(er8_dut), 64'd0);
    cycle();
    fl = 1'b0;
    #1;
    chk("fl_valid", 64'(cv8), 64'd0);
    chk("fl_grant", 64'(er8_dut), 64'h02);
    cycle();
    v8 = '0;
    #1;
    chk("fl_out_valid", 64'(cv8), 64'd1);
    chk("fl_out_data",  64'(cd8), 64'(d8[1]));

    // asynchronous reset between edges while a broadcast is pending
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_valid", 64'(cv8), 64'd0);
    chk("ar_data",  64'(cd8), 64'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    #1 chk("ar_ptr", 64'(dut8.ptr_q), 64'd0);
    cycle();

    // EU_N=7, all requesting: advance five grants, then 5,6,0,1
    do_reset();
    v7 = 7'h7F; rr7 = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    for (int k = 0; k < 4; k++) begin
      #1 chk("np2_seq", 64'(er7_dut),
             RR ? 64'(7'd1 << ((5 + k) % 7)) : 64'd1);
      cycle();
    end
    v7 = '0;
    cycle();

    // randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      fl  = ($urandom_range(0, 15) == 0);
      rr8 = ($urandom_range(0, 3) != 0);
      rr7 = ($urandom_range(0, 3) != 0);
      cycle();
      for (int i = 0; i < 8; i++) begin
        if (lg8 == i) begin
          v8[i] = 1'($urandom_range(0, 1));
          d8[i] = $urandom;
        end else if (!v8[i]) begin
          v8[i] = ($urandom_range(0, 2) == 0);
          d8[i] = $urandom;
        end
      end
      for (int i = 0; i < 7; i++) begin
        if (lg7 == i) begin
          v7[i] = 1'($urandom_range(0, 1));
          d7[i] = $urandom;
        end else if (!v7[i]) begin
          v7[i] = ($urandom_range(0, 2) == 0);
          d7[i] = $urandom;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
